// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering MAR/MBR load/store requests.
// One access at a time, WAIT_CYCLES wait states, one-cycle ack on completion.
// Optional feature macro: MEM_RANGE_CHK_EN (out-of-range address flags err,
// suppresses the write and returns zero on a read).
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                commit;
  logic                range_err;
  logic                mem_we;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Next-state logic; the *_d capture fields double as the access being
  // committed, so a zero-wait access commits straight from the inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address decode, range check and commit-side data for rdata/err.
  always_comb begin
    idx = IDX_W'(addr_d);
`ifdef MEM_RANGE_CHK_EN
    range_err = (32'(addr_d) >= 32'(DEPTH));
`else
    range_err = 1'b0;
`endif
    mem_we  = commit && we_d && !range_err;
    rdata_d = rdata_q;
    if (commit && !we_d) begin
      rdata_d = range_err ? '0 : mem_q[idx];
    end
    err_d = commit && range_err;
  end

  // Control and response registers; reset has priority over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Captured request fields; only meaningful while an access is in flight.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Storage array, never cleared; a reset on the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[idx] <= wdata_d;
    end
  end

  assign rdata = rdata_q;
  assign ack   = (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 0/1/3, DEPTH 128/256/256),
// a directed vector table, hand-written reset/drop/held-request sequences and
// randomized accesses checked against an array-based memory model.
module tb_mem_responder;

`ifdef MEM_RANGE_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int W0 = 0, W1 = 1, W2 = 3;
  localparam int D0 = 128, D1 = 256, D2 = 256;

  int W [3] = '{W0, W1, W2};
  int D [3] = '{D0, D1, D2};

  logic             clk = 1'b0;
  logic [2:0]       rst, req, we, ack, busy, err;
  logic [2:0][7:0]  addr;
  logic [2:0][15:0] wdata, rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  logic [15:0] mdl      [3][256];
  bit          known    [3][256];
  logic [15:0] rd_mdl   [3];
  bit          rd_known [3];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(D0), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]));
  mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(D1), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]));
  mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(D2), .WAIT_CYCLES(W2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2]), .err(err[2]));

  typedef struct {
    int          k;
    bit          w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One access; entered and left at a negedge with the instance idle.
  task automatic access(input int k, input bit w, input logic [7:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic e);
    int lat;
    bit got;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    tick();
    req[k] = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 40) begin
      check($sformatf("busy_k%0d", k), busy[k], 1);
      if (ack[k] === 1'b1) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check($sformatf("latency_k%0d", k), lat, 1 + W[k]);
    rd = rdata[k];
    e  = err[k];
    tick();
    check($sformatf("ack_pulse_k%0d", k), ack[k], 0);
    check($sformatf("idle_busy_k%0d", k), busy[k], 0);
  endtask

  // Memory-level model: word array indexed modulo depth, optional range check.
  task automatic model_apply(input int k, input bit w, input logic [7:0] a, input logic [15:0] d,
                             output bit exp_err);
    int idx;
    exp_err = ERR_EN && (int'(a) >= D[k]);
    idx = int'(a) % D[k];
    if (w) begin
      if (!exp_err) begin
        mdl[k][idx]   = d;
        known[k][idx] = 1'b1;
      end
    end else begin
      if (exp_err) begin
        rd_mdl[k]   = 16'h0000;
        rd_known[k] = 1'b1;
      end else begin
        rd_mdl[k]   = mdl[k][idx];
        rd_known[k] = known[k][idx];
      end
    end
  endtask

  task automatic run_op(input int k, input bit w, input logic [7:0] a, input logic [15:0] d,
                        input string nm);
    logic [15:0] rd;
    logic        e;
    bit          xe;
    access(k, w, a, d, rd, e);
    model_apply(k, w, a, d, xe);
    if (rd_known[k]) check({nm, "_rdata"}, rd, rd_mdl[k]);
    check({nm, "_err"}, e, xe);
  endtask

  initial begin
    logic [15:0] rd;
    logic        e;
    bit          xe;
    int          cnt;

    rst = 3'b111; req = '0; we = '0; addr = '0; wdata = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) known[k][i] = 1'b0;
      rd_mdl[k] = 16'h0; rd_known[k] = 1'b1;
    end
    repeat (3) tick();
    rst = 3'b000;

    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rdata_k%0d", k), rdata[k], 0);
      check($sformatf("rst_ack_k%0d", k), ack[k], 0);
      check($sformatf("rst_busy_k%0d", k), busy[k], 0);
      check($sformatf("rst_err_k%0d", k), err[k], 0);
    end

    tbl[0]  = '{1, 1'b1, 8'h05, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1, 1'b0, 8'h05, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2]  = '{1, 1'b1, 8'h05, 16'h0000, 16'hBEEF, 1'b0};
    tbl[3]  = '{1, 1'b0, 8'h05, 16'h0000, 16'h0000, 1'b0};
    tbl[4]  = '{0, 1'b1, 8'h20, 16'h1234, 16'h0000, 1'b0};
    tbl[5]  = '{0, 1'b0, 8'h20, 16'h0000, 16'h1234, 1'b0};
    tbl[6]  = '{0, 1'b1, 8'h05, 16'h5555, 16'h1234, 1'b0};
    tbl[7]  = '{0, 1'b1, 8'h85, 16'hAAAA, 16'h1234, ERR_EN};
    tbl[8]  = '{0, 1'b0, 8'h05, 16'h0000, ERR_EN ? 16'h5555 : 16'hAAAA, 1'b0};
    tbl[9]  = '{0, 1'b0, 8'h85, 16'h0000, ERR_EN ? 16'h0000 : 16'hAAAA, ERR_EN};
    tbl[10] = '{2, 1'b1, 8'h10, 16'h1111, 16'h0000, 1'b0};
    tbl[11] = '{2, 1'b1, 8'h01, 16'h0101, 16'h0000, 1'b0};
    tbl[12] = '{2, 1'b0, 8'h10, 16'h0000, 16'h1111, 1'b0};

    for (int i = 0; i < 13; i++) begin
      access(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, rd, e);
      model_apply(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, xe);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), e, tbl[i].exp_err);
    end

    // reset two cycles in the middle of a WAIT write to 0x10
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h10; wdata[2] = 16'h2222;
    tick();
    req[2] = 1'b0;
    check("abort_busy_before", busy[2], 1);
    rst[2] = 1'b1;
    tick();
    check("abort_ack_during", ack[2], 0);
    tick();
    rst[2] = 1'b0;
    check("abort_ack", ack[2], 0);
    check("abort_busy", busy[2], 0);
    check("abort_rdata", rdata[2], 0);
    check("abort_err", err[2], 0);
    rd_mdl[2] = 16'h0; rd_known[2] = 1'b1;
    run_op(2, 1'b0, 8'h10, 16'h0, "abort_readback");

    // request pulsed during WAIT is dropped
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 8'h01;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack[2] === 1'b1) cnt++;
      if (i == 0) begin
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h01; wdata[2] = 16'hFFFF;
      end else if (i == 1) begin
        req[2] = 1'b0;
      end
    end
    check("drop_ack_count", cnt, 1);
    check("drop_rdata", rdata[2], 16'h0101);
    model_apply(2, 1'b0, 8'h01, 16'h0, xe);
    run_op(2, 1'b0, 8'h01, 16'h0, "drop_readback");

    // request held high: one acceptance every WAIT_CYCLES+2 cycles
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h05;
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ack[1] === 1'b1) cnt++;
      if (i == 12) req[1] = 1'b0;
    end
    check("held_ack_count", cnt, 4);
    model_apply(1, 1'b0, 8'h05, 16'h0, xe);
    check("held_rdata", rdata[1], rd_mdl[1]);
    tick();

    // randomized accesses against the model
    for (int n = 0; n < 150; n++) begin
      int          k;
      bit          w;
      logic [7:0]  a;
      logic [15:0] d;
      k = int'($urandom_range(0, 2));
      w = bit'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      d = 16'($urandom);
      run_op(k, w, a, d, $sformatf("rand%0d_k%0d", n, k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
